// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit, K bits per cycle, start/busy/done handshake
module serial_adder #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int K  = BITS_PER_CYCLE;
   localparam int N  = WIDTH / K;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
      $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [K-1:0]     w_slice_sum;
   logic             w_slice_cout;
   logic             w_msb_cin;
   logic [WIDTH-1:0] w_res_next;
   logic             w_accept;
   logic             w_last;

   // K-bit ripple slice; w_msb_cin is the carry into the slice's top bit,
   // which on the final slice is the carry into the operand MSB.
   always_comb begin
      w_slice_sum  = '0;
      w_slice_cout = r_carry;
      w_msb_cin    = r_carry;
      for (int i = 0; i < K; i++) begin
         w_msb_cin      = w_slice_cout;
         w_slice_sum[i] = r_opa[i] ^ r_opb[i] ^ w_slice_cout;
         w_slice_cout   = (r_opa[i] & r_opb[i]) | (w_slice_cout & (r_opa[i] ^ r_opb[i]));
      end
   end

   if (K == WIDTH) begin : g_res_full
      assign w_res_next = w_slice_sum;
   end else begin : g_res_shift
      assign w_res_next = {w_slice_sum, r_res[WIDTH-1:K]};
   end

   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_cnt == CW'(N - 1));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = S_RUN;
         S_RUN:   if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_opa   <= '0;
         r_opb   <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            r_cnt   <= '0;
         end else if (r_state == S_RUN) begin
            r_opa   <= r_opa >> K;
            r_opb   <= r_opb >> K;
            r_res   <= w_res_next;
            r_carry <= w_slice_cout;
            r_cnt   <= r_cnt + CW'(1);
            // Result registers change only on completion so a new start leaves them intact.
            if (w_last) begin
               r_sum  <= w_res_next;
               r_cout <= w_slice_cout;
               r_ovf  <= w_slice_cout ^ w_msb_cin;
            end
         end
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed bench for serial_adder over several WIDTH/K pairs
module tb_serial_adder;

   localparam int NI = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NI-1:0] r_start = '0;
   logic          r_sub = 1'b0;
   logic          r_cin = 1'b0;
   logic [15:0]   r_a = '0;
   logic [15:0]   r_b = '0;
   logic [NI-1:0] w_busy, w_done, w_cout, w_ovf;
   logic [15:0]   w_sum [NI];
   logic [15:0]   exp_sum [NI];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   // instances 0..3: WIDTH 8, K = 1,2,4,8; instances 4..7: WIDTH 16, K = 1,2,4,16
   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = (g < 4) ? 8 : 16;
      localparam int K = (g % 4 == 0) ? 1 : (g % 4 == 1) ? 2 : (g % 4 == 2) ? 4 : W;
      logic [W-1:0] w_s;
      serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(K)) u_dut (
         .clk   (clk),
         .rst   (rst),
         .start (r_start[g]),
         .sub   (r_sub),
         .a     (r_a[W-1:0]),
         .b     (r_b[W-1:0]),
         .cin   (r_cin),
         .busy  (w_busy[g]),
         .done  (w_done[g]),
         .sum   (w_s),
         .cout  (w_cout[g]),
         .ovf   (w_ovf[g])
      );
      assign w_sum[g] = 16'(w_s);
   end

   function automatic int wd(input int idx);
      return (idx < 4) ? 8 : 16;
   endfunction

   function automatic int kd(input int idx);
      case (idx % 4)
         0:       return 1;
         1:       return 2;
         2:       return 4;
         default: return wd(idx);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic, unsigned for sum/carry, signed range test for overflow.
   task automatic model(input int w, input longint ua, input longint ub, input bit ci, input bit s,
                        output longint es, output bit ec, output bit eo);
      longint m, half, sa, sb, u, r;
      m    = longint'(1) << w;
      half = m / 2;
      sa   = (ua >= half) ? ua - m : ua;
      sb   = (ub >= half) ? ub - m : ub;
      if (!s) begin
         u  = ua + ub + ci;
         r  = sa + sb + ci;
         ec = (u >= m);
      end else begin
         u  = ua - ub - ci;
         r  = sa - sb - ci;
         ec = (u >= 0);
      end
      es = ((u % m) + m) % m;
      eo = (r < -half) || (r > half - 1);
   endtask

   // Called #1 after an edge; returns #1 after the edge on which done became visible
   // (chain=1) or one edge later after checking the pulse ended (chain=0).
   task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic s, input bit chain);
      int     w, n, t;
      longint mask, es;
      bit     ec, eo, seen;
      w    = wd(idx);
      n    = w / kd(idx);
      mask = (longint'(1) << w) - 1;
      model(w, longint'(a) & mask, longint'(b) & mask, ci, s, es, ec, eo);
      r_a = a; r_b = b; r_cin = ci; r_sub = s; r_start[idx] = 1'b1;
      @(posedge clk); #1;
      r_start[idx] = 1'b0;
      r_a = 16'($urandom); r_b = 16'($urandom); r_cin = 1'($urandom); r_sub = 1'($urandom);
      check("busy_after_accept", w_busy[idx], 1);
      check("sum_held_on_start", w_sum[idx], exp_sum[idx]);
      t    = 0;
      seen = 1'b0;
      while (!seen && t < 40) begin
         @(posedge clk); #1;
         t++;
         if (t == 1 && n >= 2) begin
            r_start[idx] = 1'b1; r_a = 16'($urandom); r_b = 16'($urandom);
         end
         if (t == 2) r_start[idx] = 1'b0;
         seen = w_done[idx];
      end
      check("done_latency", t + 1, n + 1);
      check("sum", w_sum[idx], 32'(es));
      check("cout", w_cout[idx], ec);
      check("ovf", w_ovf[idx], eo);
      check("busy_in_done", w_busy[idx], 0);
      exp_sum[idx] = 16'(es);
      if (!chain) begin
         @(posedge clk); #1;
         check("done_one_cycle", w_done[idx], 0);
         check("sum_hold", w_sum[idx], 32'(es));
      end
   endtask

   task automatic directed(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic s, input bit chain,
                           input logic [15:0] esum, input logic ec, input logic eo);
      run_op(idx, a, b, ci, s, chain);
      check("dir_sum", w_sum[idx], esum);
      check("dir_cout", w_cout[idx], ec);
      check("dir_ovf", w_ovf[idx], eo);
   endtask

   initial begin
      bit dn;
      for (int i = 0; i < NI; i++) exp_sum[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check("reset_busy", w_busy[i], 0);
         check("reset_done", w_done[i], 0);
         check("reset_sum", w_sum[i], 0);
         check("reset_cout_ovf", {w_cout[i], w_ovf[i]}, 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      directed(0, 16'd100, 16'd27, 1'b0, 1'b0, 1'b0, 16'd127, 1'b0, 1'b0);
      directed(0, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1);
      directed(0, 16'hFF, 16'h01, 1'b1, 1'b0, 1'b0, 16'h01, 1'b1, 1'b0);
      directed(0, 16'd5, 16'd7, 1'b0, 1'b1, 1'b0, 16'hFE, 1'b0, 1'b0);
      directed(0, 16'h80, 16'h01, 1'b0, 1'b1, 1'b0, 16'h7F, 1'b1, 1'b1);
      directed(2, 16'hA5, 16'h5A, 1'b1, 1'b0, 1'b1, 16'h00, 1'b1, 1'b0);
      directed(2, 16'h01, 16'h02, 1'b0, 1'b0, 1'b0, 16'h03, 1'b0, 1'b0);
      directed(3, 16'hFF, 16'hFF, 1'b1, 1'b0, 1'b0, 16'hFF, 1'b1, 1'b0);

      // reset in the middle of a run
      r_a = 16'h12; r_b = 16'h34; r_cin = 1'b0; r_sub = 1'b0; r_start[0] = 1'b1;
      @(posedge clk); #1;
      r_start[0] = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrun_rst_busy", w_busy[0], 0);
      check("midrun_rst_done", w_done[0], 0);
      check("midrun_rst_sum", w_sum[0], 0);
      check("midrun_rst_cout_ovf", {w_cout[0], w_ovf[0]}, 0);
      rst = 1'b0;
      for (int i = 0; i < NI; i++) exp_sum[i] = '0;
      dn = 1'b0;
      repeat (12) begin @(posedge clk); #1; dn |= w_done[0]; end
      check("midrun_rst_no_done", dn, 0);
      directed(0, 16'h12, 16'h34, 1'b0, 1'b0, 1'b0, 16'h46, 1'b0, 1'b0);

      for (int idx = 0; idx < NI; idx++) begin
         for (int k = 0; k < 25; k++) begin
            run_op(idx, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0));
         end
         @(posedge clk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
